// File: rtl/lagd_addr_region_table_if.sv
// lagd_addr_region_table_if
//   Bundles the config-write, lock and lookup handshakes of the
//   address-region table.
//   slave  : table side (lagd_addr_region_table)
//   master : requester side (config agent / demux)
// Signals:
//   cfg_valid_i/cfg_ready_o   config write handshake
//   cfg_rule_i                target entry
//   cfg_start_i/cfg_end_i     region bounds (end inclusive)
//   cfg_idx_i/cfg_en_i        slave index / entry enable
//   cfg_done_o/cfg_err_o      completion pulse and status (0 ok, 1 overlap,
//                             2 locked, 3 bad range)
//   lock_i/locked_o           sticky lock request / state
//   req_*                     lookup request handshake + address
//   resp_*                    lookup response handshake + index/hit
interface lagd_addr_region_table_if #(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned IdxWidth  = 4,
  parameter int unsigned RuleW     = 3
);
  logic                 cfg_valid_i;
  logic                 cfg_ready_o;
  logic [RuleW-1:0]     cfg_rule_i;
  logic [AddrWidth-1:0] cfg_start_i;
  logic [AddrWidth-1:0] cfg_end_i;
  logic [IdxWidth-1:0]  cfg_idx_i;
  logic                 cfg_en_i;
  logic                 cfg_done_o;
  logic [1:0]           cfg_err_o;
  logic                 lock_i;
  logic                 locked_o;
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [AddrWidth-1:0] req_addr_i;
  logic                 resp_valid_o;
  logic                 resp_ready_i;
  logic [IdxWidth-1:0]  resp_idx_o;
  logic                 resp_hit_o;

  modport slave (
    input  cfg_valid_i, cfg_rule_i, cfg_start_i, cfg_end_i, cfg_idx_i,
           cfg_en_i, lock_i, req_valid_i, req_addr_i, resp_ready_i,
    output cfg_ready_o, cfg_done_o, cfg_err_o, locked_o, req_ready_o,
           resp_valid_o, resp_idx_o, resp_hit_o
  );

  modport master (
    output cfg_valid_i, cfg_rule_i, cfg_start_i, cfg_end_i, cfg_idx_i,
           cfg_en_i, lock_i, req_valid_i, req_addr_i, resp_ready_i,
    input  cfg_ready_o, cfg_done_o, cfg_err_o, locked_o, req_ready_o,
           resp_valid_o, resp_idx_o, resp_hit_o
  );
endinterface

// File: rtl/lagd_addr_region_table.sv
// lagd_addr_region_table
//   Runtime-programmable address-region table. Holds NumRules regions
//   (start, inclusive end, slave index, enable), written through a config
//   handshake and frozen by a sticky lock. Lookups are pipelined through a
//   single output register; the lowest matching enabled entry wins, a miss
//   returns DefaultIdx with hit=0.
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset
//   bus    lagd_addr_region_table_if.slave (config, lock, lookup)
// Build option:
//   LAGD_ADDR_TABLE_OVERLAP_CHK_EN  when defined, enabled writes are checked
//   against every other enabled entry (one entry per cycle) and rejected with
//   err 1 on overlap. When undefined, enabled writes commit immediately.
//
// Config FSM:
//   state    | meaning
//   ST_IDLE  | ready for a config write
//   ST_CHECK | scanning entries for overlap (checker build only)
//   ST_DONE  | done pulse with status, not ready
module lagd_addr_region_table #(
  parameter int unsigned NumRules   = 8,
  parameter int unsigned AddrWidth  = 48,
  parameter int unsigned IdxWidth   = 4,
  parameter int unsigned DefaultIdx = 0,
  parameter int unsigned RuleW      = $clog2(NumRules)
) (
  input logic                     clk_i,
  input logic                     rst_i,
  lagd_addr_region_table_if.slave bus
);

  localparam logic [1:0] ErrOk     = 2'd0;
`ifdef LAGD_ADDR_TABLE_OVERLAP_CHK_EN
  localparam logic [1:0] ErrOvl    = 2'd1;
`endif
  localparam logic [1:0] ErrLocked = 2'd2;
  localparam logic [1:0] ErrRange  = 2'd3;

`ifdef LAGD_ADDR_TABLE_OVERLAP_CHK_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CHECK = 2'd1, ST_DONE = 2'd2} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DONE = 2'd2} state_e;
`endif

  state_e r_state, w_state_nxt;

  logic [AddrWidth-1:0] r_start [NumRules];
  logic [AddrWidth-1:0] r_end   [NumRules];
  logic [IdxWidth-1:0]  r_idx   [NumRules];
  logic [NumRules-1:0]  r_en;
  logic                 r_locked;
  logic [1:0]           r_err, w_err_nxt;

  logic                 w_cfg_ready, w_cfg_acc;
  logic                 w_commit;
  logic [RuleW-1:0]     w_wr_rule;
  logic [AddrWidth-1:0] w_wr_start, w_wr_end;
  logic [IdxWidth-1:0]  w_wr_idx;
  logic                 w_wr_en;

  logic                 r_resp_valid, r_resp_hit;
  logic [IdxWidth-1:0]  r_resp_idx;
  logic                 w_req_ready, w_req_acc;
  logic                 w_lu_hit;
  logic [IdxWidth-1:0]  w_lu_idx;

`ifdef LAGD_ADDR_TABLE_OVERLAP_CHK_EN
  // Write fields latched on accept; the scan runs as a down-counter over all
  // entries, so r_k == 0 marks the last checked entry.
  logic [RuleW-1:0]     r_req_rule;
  logic [AddrWidth-1:0] r_req_start, r_req_end;
  logic [IdxWidth-1:0]  r_req_idx;
  logic [RuleW-1:0]     r_k;
  logic                 r_ovl;
  logic                 w_chk_start;
  logic                 w_ovl_now;

  assign w_ovl_now = r_en[r_k] && (r_k != r_req_rule) &&
                     (r_req_start <= r_end[r_k]) && (r_start[r_k] <= r_req_end);
`endif

  assign w_cfg_ready = (r_state == ST_IDLE) && !rst_i;
  assign w_cfg_acc   = bus.cfg_valid_i && w_cfg_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    w_commit    = 1'b0;
    w_wr_rule   = bus.cfg_rule_i;
    w_wr_start  = bus.cfg_start_i;
    w_wr_end    = bus.cfg_end_i;
    w_wr_idx    = bus.cfg_idx_i;
    w_wr_en     = bus.cfg_en_i;
`ifdef LAGD_ADDR_TABLE_OVERLAP_CHK_EN
    w_chk_start = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_cfg_acc) begin
          w_state_nxt = ST_DONE;
          if (r_locked) begin
            w_err_nxt = ErrLocked;
          end else if (bus.cfg_en_i && (bus.cfg_start_i > bus.cfg_end_i)) begin
            w_err_nxt = ErrRange;
          end else if (!bus.cfg_en_i) begin
            w_commit  = 1'b1;
            w_err_nxt = ErrOk;
          end else begin
`ifdef LAGD_ADDR_TABLE_OVERLAP_CHK_EN
            w_state_nxt = ST_CHECK;
            w_chk_start = 1'b1;
`else
            w_commit  = 1'b1;
            w_err_nxt = ErrOk;
`endif
          end
        end
      end
`ifdef LAGD_ADDR_TABLE_OVERLAP_CHK_EN
      ST_CHECK: begin
        if (r_k == '0) begin
          w_state_nxt = ST_DONE;
          w_wr_rule   = r_req_rule;
          w_wr_start  = r_req_start;
          w_wr_end    = r_req_end;
          w_wr_idx    = r_req_idx;
          w_wr_en     = 1'b1;
          // r_ovl does not yet include the entry compared this cycle
          if (r_ovl || w_ovl_now) begin
            w_err_nxt = ErrOvl;
          end else begin
            w_commit  = 1'b1;
            w_err_nxt = ErrOk;
          end
        end
      end
`endif
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_err    <= ErrOk;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_err    <= w_err_nxt;
      r_locked <= r_locked | bus.lock_i;
    end
  end

`ifdef LAGD_ADDR_TABLE_OVERLAP_CHK_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_req_rule  <= '0;
      r_req_start <= '0;
      r_req_end   <= '0;
      r_req_idx   <= '0;
      r_k         <= '0;
      r_ovl       <= 1'b0;
    end else if (w_chk_start) begin
      r_req_rule  <= bus.cfg_rule_i;
      r_req_start <= bus.cfg_start_i;
      r_req_end   <= bus.cfg_end_i;
      r_req_idx   <= bus.cfg_idx_i;
      r_k         <= RuleW'(NumRules - 1);
      r_ovl       <= 1'b0;
    end else if (r_state == ST_CHECK) begin
      if (r_k != '0) r_k <= r_k - 1'b1;
      r_ovl <= r_ovl | w_ovl_now;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumRules; i++) begin
        r_start[i] <= '0;
        r_end[i]   <= '0;
        r_idx[i]   <= '0;
      end
      r_en <= '0;
    end else if (w_commit) begin
      r_start[w_wr_rule] <= w_wr_start;
      r_end[w_wr_rule]   <= w_wr_end;
      r_idx[w_wr_rule]   <= w_wr_idx;
      r_en[w_wr_rule]    <= w_wr_en;
    end
  end

  // Descending scan so the lowest matching entry is assigned last and wins.
  always_comb begin
    w_lu_hit = 1'b0;
    w_lu_idx = IdxWidth'(DefaultIdx);
    for (int i = NumRules - 1; i >= 0; i--) begin
      if (r_en[i] && (bus.req_addr_i >= r_start[i]) && (bus.req_addr_i <= r_end[i])) begin
        w_lu_hit = 1'b1;
        w_lu_idx = r_idx[i];
      end
    end
  end

  assign w_req_ready = (!r_resp_valid || bus.resp_ready_i) && !rst_i;
  assign w_req_acc   = bus.req_valid_i && w_req_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_idx   <= IdxWidth'(DefaultIdx);
    end else if (w_req_acc) begin
      r_resp_valid <= 1'b1;
      r_resp_hit   <= w_lu_hit;
      r_resp_idx   <= w_lu_idx;
    end else if (bus.resp_ready_i) begin
      r_resp_valid <= 1'b0;
    end
  end

  assign bus.cfg_ready_o  = w_cfg_ready;
  assign bus.cfg_done_o   = (r_state == ST_DONE);
  assign bus.cfg_err_o    = (r_state == ST_DONE) ? r_err : ErrOk;
  assign bus.locked_o     = r_locked;
  assign bus.req_ready_o  = w_req_ready;
  assign bus.resp_valid_o = r_resp_valid;
  assign bus.resp_hit_o   = r_resp_hit;
  assign bus.resp_idx_o   = r_resp_idx;

endmodule
